apb_master_arb: RTL
===================

Name: apb_master_arb

Overview:
- APB3-style bus master that shares one APB segment between two local requesters (e.g. a CPU-side port and a DMA/config sequencer).
- Arbitrates round-robin, runs the SETUP/ACCESS protocol and decodes PSEL one-hot from the address.
- Honours PREADY wait states and aborts hung transfers via a timeout counter.
- Sits above the peripheral register slaves: it is the block that sequences writes/reads into them.

Parameters:
- DWIDTH, 8, data width of PWDATA/PRDATA and requester data.
- AWIDTH, 4, address width. Upper log2(NSLV) bits select the slave.
- NSLV, 4, number of PSEL lines. Power of two, at least 2.
- TMO, 15, maximum ACCESS cycles with PREADY low before abort. Range 1..255.

Ports:
- PCLK  in  1  APB clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 transfer request. Held until req0_done.
- req0_write  in  1  1=write, 0=read.
- req0_addr  in  AWIDTH  target address.
- req0_wdata  in  DWIDTH  write data.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DWIDTH  read data, valid with req0_done.
- req0_err  out  1  timeout flag, valid with req0_done.
- req1_valid / req1_write / req1_addr / req1_wdata / req1_done / req1_rdata / req1_err: same as requester 0, for requester 1.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  ACCESS phase indicator.
- PWRITE  out  1  transfer direction.
- PADDR  out  AWIDTH  transfer address.
- PWDATA  out  DWIDTH  write data.
- PRDATA  in  DWIDTH  read data, already muxed from the selected slave.
- PREADY  in  1  slave ready. Tie-high slaves complete in the first ACCESS cycle.

Behaviour:
- Reset (async, PRESETn low): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0. All done/err/rdata outputs = 0. Round-robin pointer favours req0. Timeout counter = 0.
- Reset mid-transfer: the bus drops to idle immediately. The in-flight request gets no done pulse. Requesters re-issue after reset.
- FSM IDLE:
  - If any valid, grant and capture write/addr/wdata into registers, then go to SETUP.
  - Grant: if both valid, grant the side that was NOT granted last. If one valid, grant it.
  - The pointer updates at grant.
- FSM SETUP (exactly 1 cycle):
  - PSEL[addr[AWIDTH-1 -: log2(NSLV)]]=1, PENABLE=0.
  - PWRITE/PADDR/PWDATA come from the captured registers. PWDATA=0 for reads.
  - Next state: ACCESS.
- FSM ACCESS:
  - PSEL held, PENABLE=1, all bus signals stable.
  - Each cycle with PREADY=0 increments the timeout counter.
  - Completion: PREADY=1 sampled at the PCLK edge.
- FSM on completion:
  - Next cycle: granted reqN_done=1 for one cycle, with reqN_err=0. For reads, reqN_rdata = PRDATA captured at that edge. For writes, reqN_rdata holds its previous value.
  - PSEL/PENABLE deassert. Go to IDLE.
- FSM on timeout (counter reaches TMO with PREADY still 0):
  - Abort: same as completion but reqN_err=1 and reqN_rdata=0.
  - Counter clears on leaving ACCESS.
- Outputs are registered. Minimum cost is 3 cycles per transfer (IDLE, SETUP, ACCESS).
- Grant-to-done latency is 2 + wait-state cycles.
- Requesters may change inputs after grant, since fields are captured. A non-granted requester may drop valid freely.
- Dropping valid while granted has no effect: the transfer still completes and done still pulses.
- A request arriving in the same cycle done pulses is considered at the next IDLE.
- Timer width is ceil(log2(TMO+1)) bits. It saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS}.
  - APB_IDLE_SEL constant (all-zero PSEL).
  - Function clog2 for the decode and timer widths.
- One natural sub-module: apb_rr_arb2. It is the 2-way round-robin arbiter with pointer register, giving a one-hot grant from two valids plus an advance strobe.
- Decode, FSM and timeout counter stay in the top module.

Test Plan:
- Single write: req0 write addr=0x5, wdata=0xA7, PREADY=1 → SETUP with PSEL=4'b0010, PADDR=0x5, PWDATA=0xA7, PENABLE=0. Then ACCESS for 1 cycle with PENABLE=1. Then req0_done one cycle later, req0_err=0.
- Read with 3 wait states: req1 read addr=0xC, PREADY low for 3 ACCESS cycles then high with PRDATA=0x3C → PSEL=4'b1000. Bus signals stable for 4 ACCESS cycles. Then req1_done with req1_rdata=0x3C.
- Contention: req0 and req1 both valid continuously for 4 transfers → grant order 0,1,0,1. Each transfer takes 3 cycles. No done overlaps, exactly one PSEL bit high in SETUP/ACCESS.
- Timeout: PREADY stuck 0 with TMO=15 → abort after 15 ACCESS cycles. reqN_done=1, reqN_err=1, reqN_rdata=0. The next request proceeds normally.
- Async reset mid-ACCESS: PRESETn low for 2 cycles → PSEL/PENABLE/PADDR/PWDATA go to 0 immediately and no done pulse follows. After release, req0 is favoured on a simultaneous request.
- Invariant checks every cycle:
  - PENABLE=1 implies PSEL≠0.
  - Bus signals do not change between SETUP and completion.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master slice.
//   apb_state_t  : bus sequencer states (IDLE / SETUP / ACCESS)
//   APB_IDLE_SEL : all-zero PSEL pattern, sliced to NSLV bits by users
//   clog2        : ceiling log2 used for the slave decode and timer widths
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam int unsigned APB_MAX_SLV = 32;
  localparam logic [APB_MAX_SLV-1:0] APB_IDLE_SEL = '0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   valid[1:0]    : request lines (bit N = requester N)
//   advance       : pointer update strobe, asserted when the grant is taken
//   gnt[1:0]      : one-hot combinational grant (zero when nothing valid)
// After reset the pointer favours requester 0.
module apb_rr_arb2 (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted most recently
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_q <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB3 bus master shared by two local requesters.
//   PCLK, PRESETn                       : clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata (N=0,1) : transfer request, held until reqN_done
//   reqN_done/rdata/err                 : registered completion pulse, read data, timeout flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA    : registered APB master outputs
//   PRDATA/PREADY                       : APB slave response (PRDATA already muxed)
// Round-robin grant in IDLE, one SETUP cycle, then ACCESS until PREADY or
// TMO consecutive wait cycles (abort with err=1, rdata=0).
module apb_master_arb #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NSLV   = 4,
  parameter int TMO    = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DWIDTH-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DWIDTH-1:0] req1_rdata,
  output logic              req1_err,
  output logic [NSLV-1:0]   PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY
);

  import apb_pkg::*;

  localparam int unsigned SW = clog2(NSLV);
  localparam int unsigned TW = clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  apb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DWIDTH-1:0] rdata0_q, rdata0_d;
  logic [DWIDTH-1:0] rdata1_q, rdata1_d;

  logic [1:0] arb_valid;
  logic [1:0] gnt;
  logic       advance;

  // A requester still holds valid during its own done cycle; that belongs to
  // the finished transfer, so it is masked and only a request still present
  // afterwards is treated as new.
  assign arb_valid = {req1_valid & ~done_q[1], req0_valid & ~done_q[0]};

  apb_rr_arb2 u_arb (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .valid   (arb_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    tmr_d     = tmr_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    advance   = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          advance   = 1'b1;
          owner_d   = gnt[1];
          pwrite_d  = gnt[1] ? req1_write : req0_write;
          paddr_d   = gnt[1] ? req1_addr  : req0_addr;
          pwdata_d  = pwrite_d ? (gnt[1] ? req1_wdata : req0_wdata) : '0;
          psel_d    = APB_IDLE_SEL[NSLV-1:0];
          psel_d[paddr_d[AWIDTH-1 -: SW]] = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY || (tmr_q == TMO_LAST)) begin
          state_d         = IDLE;
          psel_d          = APB_IDLE_SEL[NSLV-1:0];
          penable_d       = 1'b0;
          tmr_d           = '0;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = ~PREADY;
          if (!PREADY) begin
            if (owner_q) rdata1_d = '0;
            else         rdata0_d = '0;
          end else if (!pwrite_q) begin
            if (owner_q) rdata1_d = PRDATA;
            else         rdata0_d = PRDATA;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = APB_IDLE_SEL[NSLV-1:0];
        penable_d = 1'b0;
        tmr_d     = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      tmr_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule
